// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: CTR-mode block stream around an external AES engine, one block in flight.
module aes_ctr_stream #(
  parameter int NB = 4,
  parameter int NK = 4,
  parameter int CTR_W = 32,
  localparam int BW = 32 * NB,
  localparam int NW = BW - CTR_W,
  localparam int KW = 32 * NK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CTR_W-1:0] ctr_init,
  input  logic [NW-1:0]    nonce,
  input  logic [KW-1:0]    key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic             out_last,
  output logic             eng_start,
  output logic [KW-1:0]    eng_key,
  output logic [BW-1:0]    eng_in,
  input  logic [BW-1:0]    eng_out,
  input  logic             eng_ready,
  output logic             busy,
  output logic             ctr_wrap
);
  typedef enum logic [1:0] {IDLE, ARMED, CRYPT, EMIT} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] key_q;
  logic [NW-1:0] nonce_q;
  logic [CTR_W-1:0] ctr_q;
  logic [BW-1:0] data_q, eng_in_q, out_data_q;
  logic last_q, out_last_q, out_valid_q, eng_start_q, ctr_wrap_q;
  logic arm, xfer, done, emit_hs;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ARMED;
      ARMED:   if (in_valid) state_d = CRYPT;
      CRYPT:   if (eng_ready) state_d = EMIT;
      EMIT:    if (out_ready) state_d = (out_last_q || &ctr_q) ? IDLE : ARMED;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == ARMED;
    busy = state_q != IDLE;
    arm = state_q == IDLE && start;
    xfer = in_ready && in_valid;
    done = state_q == CRYPT && eng_ready;
    emit_hs = state_q == EMIT && out_ready;
  end
  // A non-last handshake at an all-ones counter aborts the session and flags the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      nonce_q <= '0;
      ctr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      eng_in_q <= '0;
      eng_start_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      ctr_wrap_q <= 1'b0;
    end else begin
      eng_start_q <= xfer;
      if (arm) begin
        key_q <= key;
        nonce_q <= nonce;
        ctr_q <= ctr_init;
        ctr_wrap_q <= 1'b0;
      end
      if (xfer) begin
        data_q <= in_data;
        last_q <= in_last;
        eng_in_q <= {nonce_q, ctr_q};
      end
      if (done) begin
        out_data_q <= eng_out ^ data_q;
        out_last_q <= last_q;
        out_valid_q <= 1'b1;
      end
      if (emit_hs) begin
        out_valid_q <= 1'b0;
        if (!out_last_q) begin
          ctr_q <= ctr_q + 1'b1;
          if (&ctr_q) ctr_wrap_q <= 1'b1;
        end
      end
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign eng_start = eng_start_q;
  assign eng_key = key_q;
  assign eng_in = eng_in_q;
  assign ctr_wrap = ctr_wrap_q;
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: directed and randomized checks of aes_ctr_stream against an AES/CTR reference model.
module tb_aes_ctr_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, eng_rdy = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [127:0] iv = '0, in_data = '0, eng_out = '0;
  logic [255:0] key = '0;
  logic in_ready_a [4], out_valid_a [4], out_last_a [4], eng_start_a [4], busy_a [4], ctr_wrap_a [4];
  logic [127:0] out_data_a [4], eng_in_a [4];
  logic [127:0] ek0, ek1;
  logic [191:0] ek2;
  logic [255:0] ek3;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb [256];
  logic [127:0] m_iv;
  logic [255:0] m_key;
  int m_nk = 4, m_cw = 32;
  bit noise = 1'b0;

  aes_ctr_stream #(.NB(4), .NK(4), .CTR_W(32)) u0 (.clk(clk), .rst(rst), .start(start && sel == 2'd0),
    .ctr_init(iv[31:0]), .nonce(iv[127:32]), .key(key[255:128]), .in_valid(in_valid && sel == 2'd0),
    .in_ready(in_ready_a[0]), .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a[0]),
    .out_ready(out_ready && sel == 2'd0), .out_data(out_data_a[0]), .out_last(out_last_a[0]),
    .eng_start(eng_start_a[0]), .eng_key(ek0), .eng_in(eng_in_a[0]), .eng_out(eng_out),
    .eng_ready(eng_rdy && sel == 2'd0), .busy(busy_a[0]), .ctr_wrap(ctr_wrap_a[0]));
  aes_ctr_stream #(.NB(4), .NK(4), .CTR_W(8)) u1 (.clk(clk), .rst(rst), .start(start && sel == 2'd1),
    .ctr_init(iv[7:0]), .nonce(iv[127:8]), .key(key[255:128]), .in_valid(in_valid && sel == 2'd1),
    .in_ready(in_ready_a[1]), .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a[1]),
    .out_ready(out_ready && sel == 2'd1), .out_data(out_data_a[1]), .out_last(out_last_a[1]),
    .eng_start(eng_start_a[1]), .eng_key(ek1), .eng_in(eng_in_a[1]), .eng_out(eng_out),
    .eng_ready(eng_rdy && sel == 2'd1), .busy(busy_a[1]), .ctr_wrap(ctr_wrap_a[1]));
  aes_ctr_stream #(.NB(4), .NK(6), .CTR_W(32)) u2 (.clk(clk), .rst(rst), .start(start && sel == 2'd2),
    .ctr_init(iv[31:0]), .nonce(iv[127:32]), .key(key[255:64]), .in_valid(in_valid && sel == 2'd2),
    .in_ready(in_ready_a[2]), .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a[2]),
    .out_ready(out_ready && sel == 2'd2), .out_data(out_data_a[2]), .out_last(out_last_a[2]),
    .eng_start(eng_start_a[2]), .eng_key(ek2), .eng_in(eng_in_a[2]), .eng_out(eng_out),
    .eng_ready(eng_rdy && sel == 2'd2), .busy(busy_a[2]), .ctr_wrap(ctr_wrap_a[2]));
  aes_ctr_stream #(.NB(4), .NK(8), .CTR_W(32)) u3 (.clk(clk), .rst(rst), .start(start && sel == 2'd3),
    .ctr_init(iv[31:0]), .nonce(iv[127:32]), .key(key), .in_valid(in_valid && sel == 2'd3),
    .in_ready(in_ready_a[3]), .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a[3]),
    .out_ready(out_ready && sel == 2'd3), .out_data(out_data_a[3]), .out_last(out_last_a[3]),
    .eng_start(eng_start_a[3]), .eng_key(ek3), .eng_in(eng_in_a[3]), .eng_out(eng_out),
    .eng_ready(eng_rdy && sel == 2'd3), .busy(busy_a[3]), .ctr_wrap(ctr_wrap_a[3]));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // Straight textbook AES: key schedule, then rounds over a 16-byte column-major state.
  function automatic logic [127:0] aes(input logic [255:0] k, input int nk, input logic [127:0] pt);
    logic [31:0] w [60];
    logic [7:0] s [16], t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] r;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int rd = 0; rd <= nr; rd++) begin
      if (rd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int b = 0; b < 4; b++) s[4*c+b] = t[4*((c+b)%4)+b];
        if (rd < nr)
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
      end
      for (int c = 0; c < 4; c++)
        for (int b = 0; b < 4; b++) s[4*c+b] ^= w[4*rd+c][31-8*b -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [255:0] kmask(input logic [255:0] k, input int nk);
    return k & ~({256{1'b1}} >> (32 * nk));
  endfunction
  function automatic logic [255:0] ekey();
    case (sel)
      2'd0: return {ek0, 128'd0};
      2'd1: return {ek1, 128'd0};
      2'd2: return {ek2, 64'd0};
      default: return ek3;
    endcase
  endfunction
  // Counter block: nonce bits from the session IV, low CTR_W bits = c modulo 2^CTR_W.
  function automatic logic [127:0] blkiv(input longint c);
    logic [127:0] m;
    m = (128'd1 << m_cw) - 128'd1;
    return (m_iv & ~m) | (128'(c) & m);
  endfunction

  task automatic sess(input logic [1:0] s, input logic [127:0] v, input logic [255:0] k);
    @(negedge clk);
    sel = s; iv = v; key = k; start = 1'b1;
    m_iv = v; m_key = k;
    m_nk = (s == 2'd3) ? 8 : (s == 2'd2) ? 6 : 4;
    m_cw = (s == 2'd1) ? 8 : 32;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy_a[sel], 1);
    chk("in_ready_armed", in_ready_a[sel], 1);
    chk("wrap_cleared", ctr_wrap_a[sel], 0);
    chk("eng_key", ekey(), kmask(m_key, m_nk));
  endtask

  task automatic blk(input logic [127:0] d, input bit l, input int lat, input int bp, input longint c,
                     output logic [127:0] got);
    logic [127:0] e_in, e_out;
    longint mk;
    bit wr;
    int n;
    mk = (longint'(1) << m_cw) - 1;
    wr = !l && ((c & mk) == mk);
    e_in = blkiv(c);
    e_out = aes(m_key, m_nk, e_in) ^ d;
    if (noise) begin
      start = 1'b1;
      iv = r128();
      key = {r128(), r128()};
    end
    in_data = d; in_last = l; in_valid = 1'b1;
    n = 0;
    while (!in_ready_a[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", n < 20, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = r128();
    chk("eng_start", eng_start_a[sel], 1);
    chk("eng_in", eng_in_a[sel], e_in);
    chk("in_ready_crypt", in_ready_a[sel], 0);
    chk("eng_key_hold", ekey(), kmask(m_key, m_nk));
    eng_out = aes(m_key, m_nk, e_in);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("eng_start_pulse", eng_start_a[sel], 0);
      chk("out_valid_early", out_valid_a[sel], 0);
    end
    eng_rdy = 1'b1;
    @(negedge clk);
    eng_rdy = 1'b0;
    chk("out_valid", out_valid_a[sel], 1);
    chk("out_data", out_data_a[sel], e_out);
    chk("out_last", out_last_a[sel], l);
    chk("busy_emit", busy_a[sel], 1);
    got = out_data_a[sel];
    if (bp > 0) begin
      eng_rdy = 1'b1;
      eng_out = ~eng_out;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid_a[sel], 1);
      chk("bp_data", out_data_a[sel], e_out);
      chk("bp_in_ready", in_ready_a[sel], 0);
    end
    eng_rdy = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid_a[sel], 0);
    chk("busy_after_hs", busy_a[sel], !(l || wr));
    chk("in_ready_after_hs", in_ready_a[sel], !(l || wr));
    chk("ctr_wrap", ctr_wrap_a[sel], wr);
  endtask

  initial begin
    logic [7:0] inv;
    logic [127:0] got;
    logic [255:0] key0;
    longint c0, mk;
    int len;
    logic [1:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
    key0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", busy_a[i], 0);
      chk("rst_in_ready", in_ready_a[i], 0);
      chk("rst_out_valid", out_valid_a[i], 0);
      chk("rst_out_last", out_last_a[i], 0);
      chk("rst_eng_start", eng_start_a[i], 0);
      chk("rst_ctr_wrap", ctr_wrap_a[i], 0);
      chk("rst_out_data", out_data_a[i], 0);
      chk("rst_eng_in", eng_in_a[i], 0);
    end
    rst = 1'b0;
    sess(2'd0, 128'h0, key0);
    blk(128'h0, 1'b1, 3, 0, 0, got);
    sess(2'd0, 128'h00112233445566778899aabbccddeeff, key0);
    blk(128'h0, 1'b1, 2, 0, longint'(32'hccddeeff), got);
    chk("kat128", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    sess(2'd2, 128'h00112233445566778899aabbccddeeff, key0);
    blk(128'h0, 1'b1, 1, 0, longint'(32'hccddeeff), got);
    chk("kat192", got, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    sess(2'd3, 128'h00112233445566778899aabbccddeeff, key0);
    blk(128'h0, 1'b1, 0, 2, longint'(32'hccddeeff), got);
    chk("kat256", got, 128'h8ea2b7ca516745bfeafc49904b496089);
    sess(2'd0, {r128() >> 32, 32'd5}, {r128(), r128()});
    blk(r128(), 1'b0, 1, 0, 5, got);
    blk(r128(), 1'b0, 2, 10, 6, got);
    blk(r128(), 1'b1, 0, 0, 7, got);
    sess(2'd1, {r128() >> 8, 8'hff}, {r128(), r128()});
    blk(r128(), 1'b0, 1, 0, 255, got);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("wrap_no_accept", in_ready_a[1], 0);
      chk("wrap_no_eng", eng_start_a[1], 0);
      chk("wrap_idle", busy_a[1], 0);
    end
    in_valid = 1'b0;
    chk("wrap_sticky", ctr_wrap_a[1], 1);
    sess(2'd1, {r128() >> 8, 8'hfe}, {r128(), r128()});
    blk(r128(), 1'b0, 0, 1, 254, got);
    blk(r128(), 1'b1, 2, 0, 255, got);
    sess(2'd0, r128(), {r128(), r128()});
    in_data = r128(); in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_eng_start", eng_start_a[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy_a[0], 0);
    chk("mid_rst_eng_in", eng_in_a[0], 0);
    chk("mid_rst_eng_start", eng_start_a[0], 0);
    eng_rdy = 1'b1;
    @(negedge clk);
    eng_rdy = 1'b0;
    chk("late_rdy_valid", out_valid_a[0], 0);
    chk("late_rdy_busy", busy_a[0], 0);
    chk("late_rdy_data", out_data_a[0], 0);
    sess(2'd0, r128(), {r128(), r128()});
    blk(r128(), 1'b1, 1, 0, longint'(m_iv[31:0]), got);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start", busy_a[0], 0);
    @(negedge clk);
    chk("rst_over_start_hold", busy_a[0], 0);
    noise = 1'b1;
    for (int t = 0; t < 16; t++) begin
      s = 2'(t % 4);
      len = $urandom_range(1, 4);
      sess(s, r128(), {r128(), r128()});
      c0 = (s == 2'd1) ? longint'(m_iv[7:0]) : longint'(m_iv[31:0]);
      mk = (longint'(1) << m_cw) - 1;
      for (int i = 0; i < len; i++) begin
        blk(r128(), i == len - 1, $urandom_range(0, 4), $urandom_range(0, 3), c0 + i, got);
        if (i < len - 1 && ((c0 + i) & mk) == mk) break;
      end
    end
    noise = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
